// File: rtl/vga_fb_arbiter_if.sv
// vga_fb_arbiter_if: single-port frame-buffer memory bus.
//   mem_en    : access strobe
//   mem_we    : 1 = write, 0 = read (meaningful only while mem_en = 1)
//   mem_addr  : word address
//   mem_wdata : write data
//   mem_rdata : read data, valid exactly one cycle after a read strobe
// master = arbiter side, slave = memory side.
interface vga_fb_arbiter_if #(
  parameter int AW = 20
);
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic [15:0]   mem_rdata;

  modport master (
    output mem_en,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_en,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one 16-bit frame-buffer port between the display
// line prefetcher (bursts into a pixel FIFO) and a generic single-word writer.
//
// Ports:
//   vga_clk, rst         : clock, synchronous active-high reset
//   line_start, line_y   : pulse to start prefetching line line_y
//   wr_req/addr/data/ack : writer handshake, ack pulses in the write cycle
//   mem                  : frame-buffer bus (master side), combinational strobes
//   px_rd, px_data       : pixel pop, registered pixel out
//   underrun             : sticky, popped while the FIFO was empty
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | start a burst (issuing its first read) if credits allow, else
//        | serve the writer
// S_RD   | issue the remaining BURST-1 reads of a burst, writer locked out
module vga_fb_arbiter #(
  parameter int H_DISP = 1024,
  parameter int V_DISP = 768,
  parameter int AW     = 20,
  parameter int DEPTH  = 64,
  parameter int BURST  = 16
) (
  input  logic           vga_clk,
  input  logic           rst,
  input  logic           line_start,
  input  logic [9:0]     line_y,
  input  logic           wr_req,
  input  logic [AW-1:0]  wr_addr,
  input  logic [15:0]    wr_data,
  output logic           wr_ack,
  vga_fb_arbiter_if.master mem,
  input  logic           px_rd,
  output logic [15:0]    px_data,
  output logic           underrun
);

  localparam int XW = $clog2(H_DISP + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(BURST + 1);

  localparam logic [XW-1:0] X_END      = XW'(H_DISP);
  localparam logic [XW-1:0] X_LAST     = XW'(H_DISP - 1);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(DEPTH - BURST);
  localparam logic [BW-1:0] BEATS_RD   = BW'(BURST - 1);
  localparam logic [BW-1:0] BEAT_TC    = BW'(1);
  localparam logic [AW-1:0] PITCH      = AW'(H_DISP);

  typedef enum logic {S_IDLE, S_RD} state_t;

  state_t        state, state_nx;
  logic [AW-1:0] base;
  logic [AW-1:0] base_calc;
  logic [XW-1:0] x_next;
  logic          active;
  logic [BW-1:0] beat_cnt;
  logic          rd_issue;
  logic          rd_pending;

  logic [15:0]   fifo_mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_cnt;
  logic [CW-1:0] credits;
  logic          fifo_empty;
  logic          fifo_push;
  logic          fifo_pop;

  assign base_calc  = AW'(line_y) * PITCH;
  assign fifo_empty = (fifo_cnt == '0);
  // Reads still in flight will land in the FIFO, so they count against space.
  assign credits    = fifo_cnt + CW'(rd_pending);
  assign fifo_push  = rd_pending;
  assign fifo_pop   = px_rd && !fifo_empty;

  always_comb begin
    state_nx      = state;
    rd_issue      = 1'b0;
    wr_ack        = 1'b0;
    mem.mem_en    = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = wr_data;
    if (!rst) begin
      case (state)
        S_IDLE: begin
          // A read started alongside line_start would be discarded anyway,
          // so hold it off and let a waiting writer use the slot.
          if (!line_start && active && (x_next < X_END) && (credits <= CREDIT_MAX)) begin
            rd_issue = 1'b1;
            state_nx = (BURST > 1) ? S_RD : S_IDLE;
          end else if (wr_req) begin
            mem.mem_en   = 1'b1;
            mem.mem_we   = 1'b1;
            mem.mem_addr = wr_addr;
            wr_ack       = 1'b1;
          end
        end
        S_RD: begin
          rd_issue = 1'b1;
          if (beat_cnt == BEAT_TC) state_nx = S_IDLE;
        end
        default: state_nx = S_IDLE;
      endcase
      if (rd_issue) begin
        mem.mem_en   = 1'b1;
        mem.mem_addr = base + AW'(x_next);
      end
      if (line_start) state_nx = S_IDLE;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      state      <= S_IDLE;
      base       <= '0;
      x_next     <= '0;
      active     <= 1'b0;
      beat_cnt   <= '0;
      rd_pending <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      px_data    <= '0;
      underrun   <= 1'b0;
    end else begin
      state <= state_nx;
      // Data for a read issued alongside line_start belongs to the old line.
      rd_pending <= rd_issue && !line_start;

      if (rd_issue) begin
        if (state == S_IDLE) beat_cnt <= BEATS_RD;
        else                 beat_cnt <= beat_cnt - 1'b1;
      end

      if (px_rd) begin
        if (fifo_empty) begin
          px_data  <= '0;
          underrun <= 1'b1;
        end else begin
          px_data <= fifo_mem[rd_ptr];
        end
      end

      if (line_start) begin
        base     <= base_calc;
        x_next   <= '0;
        active   <= (int'(line_y) < V_DISP);
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        fifo_cnt <= '0;
      end else begin
        if (rd_issue) begin
          x_next <= x_next + 1'b1;
          if (x_next == X_LAST) active <= 1'b0;
        end
        if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
        if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
        fifo_cnt <= fifo_cnt + CW'(fifo_push) - CW'(fifo_pop);
      end
    end
  end

  always_ff @(posedge vga_clk) begin
    if (fifo_push && !line_start) fifo_mem[wr_ptr] <= mem.mem_rdata;
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: directed bench for vga_fb_arbiter. The memory model
// returns addr[15:0] ^ 16'h5A5A one cycle after each read strobe; strobes
// are logged on the falling edge together with the cycle number.
module tb_vga_fb_arbiter;
  localparam int AW = 20;

  logic          vga_clk = 1'b0;
  logic          rst = 1'b1;
  logic          line_start = 1'b0;
  logic [9:0]    line_y = '0;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [15:0]   wr_data = '0;
  logic          wr_ack;
  logic          px_rd = 1'b0;
  logic [15:0]   px_data;
  logic          underrun;

  vga_fb_arbiter_if #(.AW(AW)) mem_if ();

  vga_fb_arbiter #(
    .H_DISP(1024), .V_DISP(768), .AW(AW), .DEPTH(64), .BURST(16)
  ) dut (
    .vga_clk    (vga_clk),
    .rst        (rst),
    .line_start (line_start),
    .line_y     (line_y),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ack     (wr_ack),
    .mem        (mem_if),
    .px_rd      (px_rd),
    .px_data    (px_data),
    .underrun   (underrun)
  );

  always #5 vga_clk = ~vga_clk;

  function automatic logic [15:0] pix(input logic [AW-1:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  int            cyc = 0;
  int            rd_cyc[$];
  logic [AW-1:0] rd_adr[$];
  int            wr_cnt = 0;
  logic [15:0]   rdata_nx = '0;

  always @(posedge vga_clk) cyc <= cyc + 1;

  always @(negedge vga_clk) begin
    if (!rst && mem_if.mem_en) begin
      if (mem_if.mem_we) wr_cnt++;
      else begin
        rd_cyc.push_back(cyc);
        rd_adr.push_back(mem_if.mem_addr);
      end
    end
    rdata_nx = pix(mem_if.mem_addr);
  end

  always @(posedge vga_clk) mem_if.mem_rdata <= rdata_nx;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic start_line(input logic [9:0] y, output int t);
    line_y     = y;
    line_start = 1'b1;
    t          = cyc;
    tick();
    line_start = 1'b0;
  endtask

  int   t, t2, n0, b, w0, ack_cyc;
  logic got_ack;

  initial begin
    // reset with a pending write
    rst = 1'b1; wr_req = 1'b1; wr_addr = 20'h00100; wr_data = 16'hBEEF;
    tick();
    check("rst_wr_ack",   wr_ack, 0);
    check("rst_mem_en",   mem_if.mem_en, 0);
    check("rst_mem_we",   mem_if.mem_we, 0);
    check("rst_mem_addr", mem_if.mem_addr, 0);
    check("rst_px_data",  px_data, 0);
    check("rst_underrun", underrun, 0);
    tick();
    check("rst_wr_ack2",  wr_ack, 0);
    rst = 1'b0;
    #1;
    check("rel_wr_ack",    wr_ack, 1);
    check("rel_mem_we",    mem_if.mem_we, 1);
    check("rel_mem_addr",  mem_if.mem_addr, 20'h00100);
    check("rel_mem_wdata", mem_if.mem_wdata, 16'hBEEF);
    tick();
    wr_req = 1'b0;
    check("rel_wr_count", wr_cnt, 1);

    // prefetch line 2, no pops: four bursts fill the FIFO then stop
    start_line(10'd2, t);
    repeat (80) tick();
    check("pf_reads",      rd_adr.size(), 64);
    check("pf_first_cyc",  rd_cyc[0], t + 1);
    check("pf_first_adr",  rd_adr[0], 2048);
    check("pf_b0_end_adr", rd_adr[15], 2063);
    check("pf_b0_end_cyc", rd_cyc[15], t + 16);
    check("pf_b1_adr",     rd_adr[16], 2064);
    check("pf_b1_cyc",     rd_cyc[16], t + 17);
    check("pf_last_adr",   rd_adr[63], 2111);
    px_rd = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("pf_pop", px_data, pix(AW'(2048 + i)));
    end
    px_rd = 1'b0;
    repeat (30) tick();
    check("pf_resume_reads", rd_adr.size(), 80);
    check("pf_resume_adr",   rd_adr[64], 2112);

    // writer asserted mid-burst waits for the burst to end
    px_rd = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("arb_pop", px_data, pix(AW'(2064 + i)));
    end
    px_rd = 1'b0;
    n0 = rd_adr.size();
    for (int k = 0; k < 40 && rd_adr.size() == n0; k++) tick();
    check("arb_burst_seen", rd_adr.size() > n0, 1);
    b  = rd_cyc[n0];
    w0 = wr_cnt;
    wr_req = 1'b1; wr_addr = 20'h00100; wr_data = 16'h1234;
    got_ack = 1'b0; ack_cyc = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (wr_ack) begin
        got_ack = 1'b1;
        ack_cyc = cyc;
        check("arb_mem_we",    mem_if.mem_we, 1);
        check("arb_mem_addr",  mem_if.mem_addr, 20'h00100);
        check("arb_mem_wdata", mem_if.mem_wdata, 16'h1234);
        break;
      end
      tick();
    end
    check("arb_ack_seen", got_ack, 1);
    check("arb_ack_cyc",  ack_cyc, b + 16);
    tick();
    wr_req = 1'b0;
    check("arb_wr_count", wr_cnt, w0 + 1);
    check("arb_reads",    rd_adr.size(), n0 + 16);

    // full line with continuous pops
    n0 = rd_adr.size();
    start_line(10'd1, t);
    tick();
    tick();
    px_rd = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      tick();
      check("le_pop", px_data, pix(AW'(1024 + i)));
    end
    px_rd = 1'b0;
    check("le_underrun", underrun, 0);
    repeat (20) tick();
    check("le_reads",     rd_adr.size(), n0 + 1024);
    check("le_first_adr", rd_adr[n0], 1024);
    check("le_last_adr",  rd_adr[n0 + 1023], 2047);

    // pop from an empty FIFO
    px_rd = 1'b1;
    tick();
    px_rd = 1'b0;
    check("ur_px_data",  px_data, 0);
    check("ur_underrun", underrun, 1);

    // restart line 5 during the 8th read of line 4
    n0 = rd_adr.size();
    start_line(10'd4, t);
    repeat (7) tick();
    start_line(10'd5, t2);
    check("mr_restart_cyc", t2, t + 8);
    tick();
    tick();
    px_rd = 1'b1;
    tick();
    px_rd = 1'b0;
    check("mr_first_pix", px_data, pix(AW'(5120)));
    check("mr_l4_adr8",   rd_adr[n0 + 7], 4096 + 7);
    check("mr_next_adr",  rd_adr[n0 + 8], 5120);
    check("mr_next_cyc",  rd_cyc[n0 + 8], t + 9);
    check("mr_underrun",  underrun, 1);

    // line_start with an out-of-range line and a write in the same cycle
    repeat (80) tick();
    n0 = rd_adr.size();
    w0 = wr_cnt;
    wr_req = 1'b1; wr_addr = 20'h0002A; wr_data = 16'h0077;
    line_y = 10'd800; line_start = 1'b1;
    #1;
    check("ls_wr_ack",   wr_ack, 1);
    check("ls_mem_addr", mem_if.mem_addr, 20'h0002A);
    tick();
    line_start = 1'b0;
    wr_req = 1'b0;
    repeat (30) tick();
    check("ls_no_reads", rd_adr.size(), n0);
    check("ls_wr_count", wr_cnt, w0 + 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
